heap_topk: RTL and testbench

HEAP_TOPK -- requirements
Module: heap_topk

---
 rtl/heap_topk.sv | 131 +++++++++++++
 tb/tb_heap_topk.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_topk.sv
// Top-K collector: keeps the K highest-scoring records sorted (stable on ties), drains them on flush.
// Latency: insert visible next edge; first emission one edge after entering DRAIN. No backpressure; excess input is dropped and counted.
module heap_topk #(
    parameter int K         = 8,
    parameter int SCORE_LSB = 0,
    parameter int SCORE_W   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [383:0] dIn,
    input  logic         valid,
    input  logic         flush,
    output logic [383:0] dOut,
    output logic         dOutValid,
    output logic         last,
    output logic         busy,
    output logic [15:0]  dropCnt
);
    localparam int CW = $clog2(K + 1);
    localparam int IW = $clog2(K);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [IW-1:0]  rd_q, rd_d;
    logic [383:0]   slot_q [K];
    logic [383:0]   slot_d [K];
    logic [383:0]   ins    [K];
    logic [K-1:0]   take;
    logic           accept;
    logic [SCORE_W-1:0] new_score;
    logic [383:0]   dout_q, dout_d;
    logic           dvld_q, dvld_d;
    logic           last_q, last_d;
    logic [15:0]    drop_q, drop_d;
    logic           drop_inc;

    assign new_score = dIn[SCORE_LSB +: SCORE_W];

    // take[i]: slot i is at or below the insertion point. Strict compare keeps equal scores ahead of the new record.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            take[i] = (CW'(i) >= count_q) || (slot_q[i][SCORE_LSB +: SCORE_W] < new_score);
        end
        ins[0] = take[0] ? dIn : slot_q[0];
        for (int i = 1; i < K; i++) begin
            if (take[i-1])
                ins[i] = slot_q[i-1];
            else if (take[i])
                ins[i] = dIn;
            else
                ins[i] = slot_q[i];
        end
        accept = take[K-1];
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_d     = rd_q;
        slot_d   = slot_q;
        dout_d   = dout_q;
        dvld_d   = 1'b0;
        last_d   = 1'b0;
        drop_inc = 1'b0;
        drop_d   = drop_q;
        case (state_q)
            COLLECT: begin
                if (valid) begin
                    if (accept) begin
                        slot_d = ins;
                        if (count_q != CW'(K))
                            count_d = count_q + CW'(1);
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
                // A record arriving with the flush is always accepted, so the drain is non-empty.
                if (flush && (count_q != '0 || valid)) begin
                    state_d = DRAIN;
                    rd_d    = '0;
                end
            end
            DRAIN: begin
                dout_d = slot_q[rd_q];
                dvld_d = 1'b1;
                if (valid)
                    drop_inc = 1'b1;
                if (CW'(rd_q) == count_q - CW'(1)) begin
                    last_d  = 1'b1;
                    state_d = COLLECT;
                    count_d = '0;
                    rd_d    = '0;
                end else begin
                    rd_d = rd_q + IW'(1);
                end
            end
            default: state_d = COLLECT;
        endcase
        if (drop_inc && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            count_q <= '0;
            rd_q    <= '0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
            last_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
            slot_q  <= slot_d;
        end
    end

    assign dOut      = dout_q;
    assign dOutValid = dvld_q;
    assign last      = last_q;
    assign busy      = (state_q == DRAIN);
    assign dropCnt   = drop_q;
endmodule

// File: tb/tb_heap_topk.sv
// Bench for heap_topk: queue-based top-K reference model, directed scenarios plus randomized rounds.
module tb_heap_topk;
    localparam int K = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [383:0] dIn = '0;
    logic         valid = 1'b0;
    logic         flush = 1'b0;
    logic [383:0] dOut;
    logic         dOutValid, last, busy;
    logic [15:0]  dropCnt;

    int errors = 0;
    int checks = 0;

    logic [383:0] model_q[$];
    int           model_drop = 0;
    logic [383:0] got_q[$];
    bit           last_q[$];
    int           busy_n;
    bit           first_vld;

    heap_topk #(.K(K), .SCORE_LSB(0), .SCORE_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .dIn(dIn), .valid(valid), .flush(flush),
        .dOut(dOut), .dOutValid(dOutValid), .last(last), .busy(busy), .dropCnt(dropCnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sc(logic [383:0] r);
        return r[15:0];
    endfunction

    function automatic logic [383:0] mkrec(int score);
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
        r[15:0] = 16'(score);
        return r;
    endfunction

    // Reference: sorted list, new record goes before the first strictly lower score.
    function automatic void model_insert(logic [383:0] r);
        int pos = model_q.size();
        for (int i = 0; i < model_q.size(); i++) begin
            if (sc(model_q[i]) < sc(r)) begin
                pos = i;
                break;
            end
        end
        if (pos >= K) begin
            if (model_drop < 65535) model_drop++;
        end else begin
            model_q.insert(pos, r);
            if (model_q.size() > K) void'(model_q.pop_back());
        end
    endfunction

    task automatic send(logic [383:0] r);
        dIn = r;
        valid = 1'b1;
        step();
        valid = 1'b0;
        model_insert(r);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    // Collects emissions after the flush edge; flush is toggled randomly while busy.
    task automatic run_drain();
        got_q.delete();
        last_q.delete();
        busy_n = 0;
        first_vld = dOutValid;
        for (int c = 0; c < K + 6; c++) begin
            if (busy) busy_n++;
            flush = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            if (dOutValid) begin
                got_q.push_back(dOut);
                last_q.push_back(last);
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b1;
        flush = 1'b1;
        dIn = mkrec(99);
        step();
        step();
        valid = 1'b0;
        flush = 1'b0;
        rst_n = 1'b1;
        model_q.delete();
        model_drop = 0;
        checks++;
        if ({dOut, dOutValid, last, busy, dropCnt} !== '0)
            begin errors++; $display("FAIL reset_outputs got vld=%b last=%b busy=%b drop=%0d dout_nz=%b want all 0", dOutValid, last, busy, dropCnt, |dOut); end
    endtask

    task automatic test_basic();
        int exp_sc[4] = '{9, 7, 5, 1};
        send(mkrec(5)); send(mkrec(9)); send(mkrec(1)); send(mkrec(7));
        do_flush();
        run_drain();
        checks++;
        if (first_vld !== 1'b0) begin errors++; $display("FAIL basic_first_latency dOutValid=%b at flush edge want 0", first_vld); end
        checks++;
        if (busy_n !== 4) begin errors++; $display("FAIL basic_busy_cycles got %0d want 4", busy_n); end
        checks++;
        if (got_q.size() !== 4) begin errors++; $display("FAIL basic_count got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++;
            if (got_q[i] !== model_q[i] || int'(sc(got_q[i])) !== exp_sc[i] || last_q[i] !== (i == 3))
                begin errors++; $display("FAIL basic_rec%0d got score %0d last %b want score %0d last %b", i, sc(got_q[i]), last_q[i], exp_sc[i], i == 3); end
        end
        model_q.delete();
    endtask

    task automatic test_topk();
        for (int s = 1; s <= 10; s++) send(mkrec(s));
        checks++;
        if (dropCnt !== 16'(model_drop) || model_drop !== 0) begin errors++; $display("FAIL topk_nodrop got %0d want 0", dropCnt); end
        send(mkrec(2));
        checks++;
        if (dropCnt !== 16'd1) begin errors++; $display("FAIL topk_drop got %0d want 1", dropCnt); end
        do_flush();
        run_drain();
        checks++;
        if (got_q.size() !== K) begin errors++; $display("FAIL topk_count got %0d want %0d", got_q.size(), K); end
        for (int i = 0; i < got_q.size() && i < K; i++) begin
            checks++;
            if (got_q[i] !== model_q[i] || int'(sc(got_q[i])) !== 10 - i || last_q[i] !== (i == K - 1))
                begin errors++; $display("FAIL topk_rec%0d got score %0d last %b want score %0d", i, sc(got_q[i]), last_q[i], 10 - i); end
        end
        model_q.delete();
    endtask

    task automatic test_stable();
        logic [383:0] a, b;
        a = mkrec(4);
        b = mkrec(4);
        a[383:380] = 4'hA;
        b[383:380] = 4'hB;
        send(a); send(b);
        do_flush();
        run_drain();
        checks++;
        if (got_q.size() !== 2 || got_q[0] !== a || got_q[1] !== b || last_q[1] !== 1'b1)
            begin errors++; $display("FAIL stable_order got n=%0d tag0=%h tag1=%h want n=2 tag0=a tag1=b", got_q.size(), got_q[0][383:380], got_q[1][383:380]); end
        model_q.delete();
    endtask

    task automatic test_valid_flush();
        logic [383:0] r;
        int seen = 0;
        r = mkrec(6);
        dIn = r;
        valid = 1'b1;
        flush = 1'b1;
        step();
        valid = 1'b0;
        flush = 1'b0;
        run_drain();
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== r || last_q[0] !== 1'b1)
            begin errors++; $display("FAIL valid_flush got n=%0d score=%0d want n=1 score=6 last=1", got_q.size(), sc(got_q[0])); end
        do_flush();
        for (int c = 0; c < 10; c++) begin
            if (dOutValid || busy) seen++;
            step();
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flush_empty got %0d active cycles want 0", seen); end
    endtask

    task automatic test_drain_drop_reset();
        int drops = 0;
        int vld_after = 0;
        logic [383:0] r;
        logic [15:0] d0;
        for (int i = 0; i < 3; i++) send(mkrec($urandom_range(10, 500)));
        d0 = dropCnt;
        do_flush();
        got_q.delete();
        for (int c = 0; c < K + 4; c++) begin
            valid = busy;
            dIn = mkrec(1000);
            if (busy) drops++;
            step();
            if (dOutValid) got_q.push_back(dOut);
        end
        valid = 1'b0;
        checks++;
        if (got_q.size() !== 3) begin errors++; $display("FAIL drain_valid_count got %0d want 3", got_q.size()); end
        checks++;
        if (dropCnt !== d0 + 16'(drops)) begin errors++; $display("FAIL drain_drop got %0d want %0d", dropCnt, d0 + 16'(drops)); end
        model_q.delete();
        for (int i = 0; i < 3; i++) send(mkrec($urandom_range(10, 500)));
        do_flush();
        step();
        rst_n = 1'b0;
        valid = 1'b1;
        flush = 1'b1;
        step();
        rst_n = 1'b1;
        valid = 1'b0;
        flush = 1'b0;
        model_q.delete();
        model_drop = 0;
        checks++;
        if (dOutValid !== 1'b0 || busy !== 1'b0 || dropCnt !== 16'd0)
            begin errors++; $display("FAIL reset_in_drain got vld=%b busy=%b drop=%0d want 0 0 0", dOutValid, busy, dropCnt); end
        do_flush();
        for (int c = 0; c < 6; c++) begin
            if (dOutValid) vld_after++;
            step();
        end
        checks++;
        if (vld_after !== 0) begin errors++; $display("FAIL reset_count_cleared got %0d emissions want 0", vld_after); end
        r = mkrec(3);
        send(r);
        do_flush();
        run_drain();
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== r) begin errors++; $display("FAIL post_reset_drain got n=%0d want 1", got_q.size()); end
        model_q.delete();
    endtask

    task automatic test_random();
        for (int round = 0; round < 12; round++) begin
            int n = $urandom_range(1, 2 * K);
            for (int i = 0; i < n; i++) begin
                send(mkrec($urandom_range(0, 20)));
                if ($urandom_range(0, 3) == 0) step();
            end
            checks++;
            if (dropCnt !== 16'(model_drop)) begin errors++; $display("FAIL rand%0d_drop got %0d want %0d", round, dropCnt, model_drop); end
            do_flush();
            run_drain();
            checks++;
            if (got_q.size() !== model_q.size() || busy_n !== model_q.size())
                begin errors++; $display("FAIL rand%0d_count got %0d busy %0d want %0d", round, got_q.size(), busy_n, model_q.size()); end
            for (int i = 0; i < got_q.size() && i < model_q.size(); i++) begin
                checks++;
                if (got_q[i] !== model_q[i] || last_q[i] !== (i == model_q.size() - 1))
                    begin errors++; $display("FAIL rand%0d_rec%0d got score %0d last %b want score %0d", round, i, sc(got_q[i]), last_q[i], sc(model_q[i])); end
            end
            model_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_topk();
        test_stable();
        test_valid_flush();
        test_drain_drop_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
